mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester arbiter in front of one shared memory port.
// Requester 0 (core) and requester 1 (DMA/debug) take turns: a tie in IDLE goes
// to whichever requester was not served last. A grant lasts until the shared
// port answers with s_ready, or until the owner drops its request.
// All data paths are combinational muxes; the only state is the FSM, the
// last_served flag and (optionally) the watchdog counter.
// Optional feature: define ARB_WATCHDOG_EN to add an 8-bit BUSY-cycle watchdog
// that aborts a transaction after TIMEOUT_CYCLES cycles without s_ready.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    m0_valid,
    output logic                    m0_ready,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    input  logic                    m1_valid,
    output logic                    m1_ready,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic                    s_valid,
    input  logic                    s_ready,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              grant,
    output logic                    timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   last_served;       // 0 = m0 served last, 1 = m1 served last
    logic   next_last_served;
    logic   owner_valid;       // request line of the current owner
    logic   wd_hit;            // this BUSY cycle is the last one the watchdog allows
    logic   wd_abort;          // watchdog ends the transaction this cycle

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 || (DATA_WIDTH % 8) != 0) begin : g_bad_params
        $error("mem_port_arbiter: TIMEOUT_CYCLES must be 1..255 and DATA_WIDTH a multiple of 8");
    end

    assign owner_valid = (state == BUSY0) ? m0_valid :
                         (state == BUSY1) ? m1_valid : 1'b0;

    // A timeout only applies to a live request that the memory has not answered.
    assign wd_abort = wd_hit && owner_valid && !s_ready;

`ifdef ARB_WATCHDOG_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wd_cnt;

    // Count BUSY cycles; restart on entry to BUSY and whenever BUSY ends.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt <= '0;
        end else if (state == IDLE || next_state == IDLE) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    assign wd_hit = (state != IDLE) && (wd_cnt == WD_LAST);
`else
    assign wd_hit = 1'b0;
`endif

    // State register and fairness flag; reset makes m0 win the first tie.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (!resetn) begin
            state       <= IDLE;
            last_served <= 1'b1;
        end else begin
            state       <= next_state;
            last_served <= next_last_served;
        end
    end

    // Next state: arbitrate in IDLE, leave BUSY on completion, abort or timeout.
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        next_state       = state;
        next_last_served = last_served;
        case (state)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    next_state = last_served ? BUSY0 : BUSY1;
                end else if (m0_valid) begin
                    next_state = BUSY0;
                end else if (m1_valid) begin
                    next_state = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                if (s_ready || wd_abort) begin
                    next_state       = IDLE;
                    next_last_served = (state == BUSY1);
                end else if (!owner_valid) begin
                    // Owner withdrew without a response: drop it, fairness unchanged.
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs: mux the owner onto the shared port and route the response back.
    always_comb begin
        s_valid  = 1'b0;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = '0;
        grant    = 2'b00;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = s_rdata;
        m1_rdata = s_rdata;
        timeout  = wd_abort;
        case (state)
            BUSY0: begin
                grant    = 2'b01;
                s_valid  = m0_valid && !wd_abort;
                s_wstrb  = m0_wstrb;
                m0_ready = s_ready || wd_abort;
                if (wd_abort) m0_rdata = '0;
            end
            BUSY1: begin
                grant    = 2'b10;
                s_valid  = m1_valid && !wd_abort;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = s_ready || wd_abort;
                if (wd_abort) m1_rdata = '0;
            end
            default: ;
        endcase
    end

endmodule
